// File: rtl/cordic_prerotate.sv
`default_nettype none
//==============================================================================
// Module      : cordic_prerotate
// Description : Input stage of the pipelined CORDIC. Applies a +/-90 degree
//               quadrant pre-rotation so the residual angle handed to the
//               shift/accumulate chain lies in [-90, +90] degrees, registers
//               x/y/z for stage 0, and keeps a {valid, tag} delay line that
//               lines up with the result at the last stage, plus an in-flight
//               sample count.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters  : WIDTH  - datapath width of x/y/z (signed two's complement)
//               STAGES - number of shift/accumulate stages downstream
//               TAG_W  - width of the user tag carried with each sample
// Ports       : clk, rst (async, active high)
//               in_valid, x_in, y_in, z_in, in_tag, flush    - inputs
//               x_out, y_out, z_out, tan0                    - to stage 0
//               res_valid, res_tag                           - aligned with
//                                                              final stage
//               in_flight, busy                              - occupancy
// Option      : CORDIC_ROTATION_INIT_EN - when defined, x_in/y_in are ignored
//               and the constant vector (K, 0) is pre-rotated instead, so the
//               final stage yields cos(z_in)/sin(z_in) scaled by 2^(WIDTH-2).
//==============================================================================
module cordic_prerotate #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 16,
    parameter int TAG_W  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              x_in,
    input  logic [WIDTH-1:0]              y_in,
    input  logic [WIDTH-1:0]              z_in,
    input  logic [TAG_W-1:0]              in_tag,
    input  logic                          flush,
    output logic [WIDTH-1:0]              x_out,
    output logic [WIDTH-1:0]              y_out,
    output logic [WIDTH-1:0]              z_out,
    output logic [WIDTH-1:0]              tan0,
    output logic                          res_valid,
    output logic [TAG_W-1:0]              res_tag,
    output logic [$clog2(STAGES+2)-1:0]   in_flight,
    output logic                          busy
);

    localparam int CNT_W = $clog2(STAGES + 2);

    // +90 and -90 degrees in binary angle format (2^WIDTH = 360 degrees).
    localparam logic [WIDTH-1:0] C_Q90     = {2'b01, {(WIDTH-2){1'b0}}};
    localparam logic [WIDTH-1:0] C_Q90_NEG = {2'b11, {(WIDTH-2){1'b0}}};
    // atan(2^0) = 45 degrees.
    localparam logic [WIDTH-1:0] C_TAN0    = {3'b001, {(WIDTH-3){1'b0}}};

    //--------------------------------------------------------------------------
    // Source vector
    //--------------------------------------------------------------------------
    logic [WIDTH-1:0] w_src_x;
    logic [WIDTH-1:0] w_src_y;

`ifdef CORDIC_ROTATION_INIT_EN
    // CORDIC gain compensation K = 0.6072529..., held at 2^62 scale so the top
    // WIDTH bits give K * 2^(WIDTH-2) (0x26DD3B6A at WIDTH=32, WIDTH <= 64).
    localparam logic [63:0]      C_K64 = {32'h26DD_3B6A, 32'h0000_0000};
    localparam logic [WIDTH-1:0] C_K   = C_K64[63 -: WIDTH];

    assign w_src_x = C_K;
    assign w_src_y = '0;
`else
    assign w_src_x = x_in;
    assign w_src_y = y_in;
`endif

    //--------------------------------------------------------------------------
    // Quadrant pre-rotation (wrapping arithmetic, no saturation)
    //--------------------------------------------------------------------------
    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] z_d;

    always_comb begin
        x_d = w_src_x;
        y_d = w_src_y;
        z_d = z_in;
        if ($signed(z_in) > $signed(C_Q90)) begin
            // rotate by +90: (x, y) -> (-y, x)
            x_d = -w_src_y;
            y_d = w_src_x;
            z_d = z_in - C_Q90;
        end else if ($signed(z_in) < $signed(C_Q90_NEG)) begin
            // rotate by -90: (x, y) -> (y, -x); -180 lands on -90 here
            x_d = w_src_y;
            y_d = -w_src_x;
            z_d = z_in + C_Q90;
        end
    end

    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] z_q;

    // Datapath loads every cycle; only the valid bit qualifies the sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
        end
    end

    //--------------------------------------------------------------------------
    // {valid, tag} delay line: entry 0 lines up with x_out, entry STAGES with
    // the final shift/accumulate stage output.
    //--------------------------------------------------------------------------
    logic [STAGES:0]  vld_q;
    logic [TAG_W-1:0] tag_q [0:STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i <= STAGES; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            // A sample arriving alongside flush still enters as valid.
            vld_q[0] <= in_valid;
            tag_q[0] <= in_tag;
            for (int i = 1; i <= STAGES; i++) begin
                vld_q[i] <= flush ? 1'b0 : vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    //--------------------------------------------------------------------------
    // In-flight count: tracks the number of set bits in vld_q incrementally.
    //--------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(in_valid) - CNT_W'(vld_q[STAGES]);
        if (flush) begin
            cnt_d = CNT_W'(in_valid);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign x_out     = x_q;
    assign y_out     = y_q;
    assign z_out     = z_q;
    assign tan0      = C_TAN0;
    assign res_valid = vld_q[STAGES];
    assign res_tag   = tag_q[STAGES];
    assign in_flight = cnt_q;
    assign busy      = (cnt_q != '0);

endmodule
`default_nettype wire
